prbs31_checker: RTL and testbench
=================================

PRBS31_CHECKER -- requirements
Module: prbs31_checker

Interface
REQ-001 SHALL have parameter LOCK_MATCHES, default 64, consecutive correct bits required to declare lock.
REQ-002 SHALL have parameter LOSS_ERRS, default 8, errors within one window that force loss of lock.
REQ-003 SHALL have parameter WIN_LEN, default 128, loss-detection window length in valid bits.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-high (rst_n=1 resets).
REQ-006 din  input  1  received serial PRBS31 bit (x^31+x^28+1 stream from the generator stage).
REQ-007 din_valid  input  1  din sampled only on cycles where din_valid=1.
REQ-008 clr_cnt  input  1  synchronous clear of err_count.
REQ-009 locked  output  1  checker synchronised to stream.
REQ-010 err_pulse  output  1  one-cycle pulse per detected bit error while locked.
REQ-011 err_count  output  16  total errors detected while locked, saturating.

Function
REQ-012 SHALL hold 31-bit history sh; sh[0] newest bit; prediction pred = sh[27] ^ sh[30]; mismatch = din ^ pred.
REQ-013 SHALL advance nothing (all state held) on cycles with din_valid=0.
REQ-014 SHALL implement states FILL, CHECK, LOCKED.
REQ-015 FILL: each valid bit shifts sh <= {sh[29:0], din}; fill counter increments; after 31st valid bit -> CHECK, match counter = 0.
REQ-016 CHECK: each valid bit shifts in din; mismatch -> match counter = 0; match -> match counter + 1.
REQ-017 CHECK: if sh == 0 after shift, match counter SHALL be forced to 0 (all-zero stream never locks).
REQ-018 CHECK -> LOCKED on the valid bit making match counter reach LOCK_MATCHES; locked=1 the following cycle.
REQ-019 LOCKED: sh SHALL shift in pred (not din), so channel errors do not corrupt the reference.
REQ-020 LOCKED: mismatch -> err_pulse=1 for exactly the next cycle; err_count += 1 saturating at 16'hFFFF.
REQ-021 LOCKED: window counter counts valid bits 0..WIN_LEN-1; window error counter counts mismatches, including the current bit.
REQ-022 Window error counter reaching LOSS_ERRS -> FILL next cycle, locked=0, fill counter = 0; that error still counts in err_count.
REQ-023 Window counter wrapping WIN_LEN-1 -> 0 clears window error counter after evaluating the current bit.
REQ-024 clr_cnt=1 -> err_count = 0 next cycle; simultaneous clr_cnt and error -> err_count = 1.
REQ-025 Errors in FILL or CHECK SHALL NOT pulse err_pulse or change err_count.
REQ-026 err_count SHALL persist across loss of lock until clr_cnt or reset.

Reset
REQ-027 rst_n=1 SHALL immediately force state FILL, sh=0, all counters=0, locked=0, err_pulse=0, err_count=0.
REQ-028 rst_n asserted mid-LOCKED SHALL drop locked asynchronously; re-lock requires full FILL+CHECK (31+LOCK_MATCHES valid bits).

Verification
REQ-029 Clean PRBS31 stream, din_valid=1 continuous -> locked=1 on cycle after valid bit 95 (31+64); err_count stays 0 over 10000 bits.
REQ-030 Locked, invert one bit -> exactly one err_pulse cycle, err_count=1, locked stays 1, following bits error-free (no triple-error echo).
REQ-031 Locked, invert 8 bits within 128-bit window -> locked=0 cycle after 8th error, err_count=8; clean stream re-locks after 95 more valid bits.
REQ-032 All-zero din for 500 bits -> locked never asserts, err_count=0.
REQ-033 din_valid toggled 50% random on clean stream -> lock after 95 valid bits; no errors; state frozen on invalid cycles.
REQ-034 Force err_count to 16'hFFFF via sustained errors (LOSS_ERRS large) -> saturates at FFFF; clr_cnt with simultaneous error -> 1.

Source files
------------

// File: rtl/prbs31_if.sv
// Serial PRBS31 checker bus: the received bit stream and the checker status.
// The master drives the stream. The slave (the checker) reports lock and error information.
interface prbs31_if;
    logic        din;
    logic        din_valid;
    logic        clr_cnt;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;

    modport master (output din, output din_valid, output clr_cnt,
                    input  locked, input err_pulse, input err_count);
    modport slave  (input  din, input din_valid, input clr_cnt,
                    output locked, output err_pulse, output err_count);
endinterface

// File: rtl/prbs31_checker.sv
// PRBS31 (x^31+x^28+1) stream checker: fills a 31-bit history, qualifies the stream,
// then free-runs its own reference while locked and counts bit errors.
module prbs31_checker #(
    parameter int unsigned LOCK_MATCHES = 64,
    parameter int unsigned LOSS_ERRS    = 8,
    parameter int unsigned WIN_LEN      = 128
) (
    input  logic      clk,
    input  logic      rst_n,
    prbs31_if.slave   bus
);

    localparam int MW = $clog2(LOCK_MATCHES + 1);
    localparam int EW = $clog2(LOSS_ERRS + 1);
    localparam int WW = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam logic [MW-1:0] LOCK_M   = MW'(LOCK_MATCHES);
    localparam logic [EW-1:0] LOSS_M   = EW'(LOSS_ERRS);
    localparam logic [WW-1:0] WIN_LAST = WW'(WIN_LEN - 1);

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    function automatic logic prbs_pred(input logic [30:0] hist);
        return hist[27] ^ hist[30];
    endfunction

    state_t        state_q, state_d;
    logic [30:0]   sh_q, sh_d;
    logic [4:0]    fill_q, fill_d;
    logic [MW-1:0] match_q, match_d;
    logic [WW-1:0] win_q, win_d;
    logic [EW-1:0] werr_q, werr_d;
    logic [15:0]   err_count_q, err_count_d;
    logic          err_pulse_q, err_pulse_d;
    logic          locked_q, locked_d;

    logic          pred_s;
    logic          mismatch_s;
    logic          err_hit_s;
    logic [30:0]   sh_din_s;
    logic [MW-1:0] match_inc_s;
    logic [EW-1:0] werr_inc_s;

    assign pred_s      = prbs_pred(sh_q);
    assign mismatch_s  = bus.din ^ pred_s;
    assign sh_din_s    = {sh_q[29:0], bus.din};
    assign match_inc_s = match_q + MW'(1);
    assign werr_inc_s  = werr_q + EW'(mismatch_s);

    // Next-state logic: history, qualification counters, window tracking and error counter
    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        fill_d      = fill_q;
        match_d     = match_q;
        win_d       = win_q;
        werr_d      = werr_q;
        err_hit_s   = 1'b0;
        if (bus.din_valid) begin
            case (state_q)
                ST_FILL: begin
                    sh_d = sh_din_s;
                    if (fill_q == 5'd30) begin
                        state_d = ST_CHECK;
                        fill_d  = 5'd0;
                        match_d = '0;
                    end else begin
                        fill_d = fill_q + 5'd1;
                    end
                end
                ST_CHECK: begin
                    sh_d = sh_din_s;
                    // An all-zero history is a degenerate stream and must never qualify
                    if (mismatch_s || (sh_din_s == 31'd0)) begin
                        match_d = '0;
                    end else if (match_inc_s == LOCK_M) begin
                        state_d = ST_LOCKED;
                        match_d = '0;
                        win_d   = '0;
                        werr_d  = '0;
                    end else begin
                        match_d = match_inc_s;
                    end
                end
                ST_LOCKED: begin
                    // The reference free-runs on its own prediction, so line errors stay isolated
                    sh_d      = {sh_q[29:0], pred_s};
                    err_hit_s = mismatch_s;
                    if (werr_inc_s == LOSS_M) begin
                        state_d = ST_FILL;
                        fill_d  = 5'd0;
                        match_d = '0;
                        win_d   = '0;
                        werr_d  = '0;
                    end else if (win_q == WIN_LAST) begin
                        win_d  = '0;
                        werr_d = '0;
                    end else begin
                        win_d  = win_q + WW'(1);
                        werr_d = werr_inc_s;
                    end
                end
                default: begin
                    state_d = ST_FILL;
                    sh_d    = 31'd0;
                    fill_d  = 5'd0;
                    match_d = '0;
                    win_d   = '0;
                    werr_d  = '0;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        if (bus.clr_cnt) begin
            err_count_d = err_hit_s ? 16'd1 : 16'd0;
        end else if (err_hit_s && (err_count_q != 16'hFFFF)) begin
            err_count_d = err_count_q + 16'd1;
        end else begin
            err_count_d = err_count_q;
        end

        err_pulse_d = err_hit_s;
        locked_d    = (state_d == ST_LOCKED);
    end

    // State and output registers, cleared asynchronously while rst_n is high
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q     <= ST_FILL;
            sh_q        <= 31'd0;
            fill_q      <= 5'd0;
            match_q     <= '0;
            win_q       <= '0;
            werr_q      <= '0;
            err_count_q <= 16'd0;
            err_pulse_q <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            win_q       <= win_d;
            werr_q      <= werr_d;
            err_count_q <= err_count_d;
            err_pulse_q <= err_pulse_d;
            locked_q    <= locked_d;
        end
    end

    assign bus.locked    = locked_q;
    assign bus.err_pulse = err_pulse_q;
    assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_prbs31_checker.sv
// Directed bench for prbs31_checker: lock timing, single/burst errors, zero stream,
// gapped valid, asynchronous reset and counter saturation on a large-LOSS_ERRS instance.
module tb_prbs31_checker;

    logic clk;
    logic rst1;
    logic rst2;
    prbs31_if b1 ();
    prbs31_if b2 ();

    prbs31_checker u_dut1 (.clk(clk), .rst_n(rst1), .bus(b1));
    prbs31_checker #(.LOCK_MATCHES(64), .LOSS_ERRS(200), .WIN_LEN(128))
        u_dut2 (.clk(clk), .rst_n(rst2), .bus(b2));

    always #5 clk = ~clk;

    int          n_cmp;
    int          n_bad;
    int          lk;
    int          nv;
    int unsigned r;
    logic [30:0] g;
    logic        gb;
    logic        pulse_seen;
    logic        locked_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference generator: next bit = g[27]^g[30], g[0] newest
    task automatic gen(output logic b);
        b = g[27] ^ g[30];
        g = {g[29:0], b};
    endtask

    task automatic tick1(input logic b, input logic v);
        b1.din = b;
        b1.din_valid = v;
        @(posedge clk);
        #1;
        if (b1.err_pulse) pulse_seen = 1'b1;
        if (b1.locked) locked_seen = 1'b1;
    endtask

    task automatic tick2(input logic b, input logic v);
        b2.din = b;
        b2.din_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic clean1(input int n);
        logic b;
        for (int i = 0; i < n; i++) begin
            gen(b);
            tick1(b, 1'b1);
            lk++;
        end
    endtask

    task automatic err1();
        logic b;
        gen(b);
        tick1(~b, 1'b1);
        lk++;
    endtask

    initial begin
        clk = 1'b0;
        n_cmp = 0;
        n_bad = 0;
        lk = 0;
        pulse_seen = 1'b0;
        locked_seen = 1'b0;
        rst1 = 1'b1;
        rst2 = 1'b1;
        b1.din = 1'b0; b1.din_valid = 1'b0; b1.clr_cnt = 1'b0;
        b2.din = 1'b0; b2.din_valid = 1'b0; b2.clr_cnt = 1'b0;
        #12;
        chk("rst_locked", {31'd0, b1.locked}, 32'd0);
        chk("rst_pulse", {31'd0, b1.err_pulse}, 32'd0);
        chk("rst_count", {16'd0, b1.err_count}, 32'd0);
        rst1 = 1'b0;

        // Clean stream: lock follows valid bit 95
        g = 31'h1A5A_1234;
        clean1(94);
        chk("lock_bit94", {31'd0, b1.locked}, 32'd0);
        clean1(1);
        chk("lock_bit95", {31'd0, b1.locked}, 32'd1);
        lk = 0;
        pulse_seen = 1'b0;
        clean1(10000);
        chk("clean_nopulse", {31'd0, pulse_seen}, 32'd0);
        chk("clean_count", {16'd0, b1.err_count}, 32'd0);
        chk("clean_locked", {31'd0, b1.locked}, 32'd1);

        // Single inverted bit
        err1();
        chk("single_pulse", {31'd0, b1.err_pulse}, 32'd1);
        chk("single_count", {16'd0, b1.err_count}, 32'd1);
        chk("single_locked", {31'd0, b1.locked}, 32'd1);
        clean1(1);
        chk("single_pulse_end", {31'd0, b1.err_pulse}, 32'd0);
        pulse_seen = 1'b0;
        clean1(200);
        chk("no_echo", {31'd0, pulse_seen}, 32'd0);
        chk("single_count_hold", {16'd0, b1.err_count}, 32'd1);
        chk("single_locked_hold", {31'd0, b1.locked}, 32'd1);

        b1.clr_cnt = 1'b1;
        tick1(1'b0, 1'b0);
        b1.clr_cnt = 1'b0;
        chk("clr_count", {16'd0, b1.err_count}, 32'd0);

        // Burst of 8 errors aligned to a window start forces loss of lock
        clean1((128 - (lk % 128)) % 128);
        repeat (7) err1();
        chk("burst7_locked", {31'd0, b1.locked}, 32'd1);
        chk("burst7_count", {16'd0, b1.err_count}, 32'd7);
        err1();
        chk("burst8_unlock", {31'd0, b1.locked}, 32'd0);
        chk("burst8_count", {16'd0, b1.err_count}, 32'd8);
        chk("burst8_pulse", {31'd0, b1.err_pulse}, 32'd1);
        clean1(94);
        chk("relock_bit94", {31'd0, b1.locked}, 32'd0);
        clean1(1);
        chk("relock_bit95", {31'd0, b1.locked}, 32'd1);
        chk("count_persist", {16'd0, b1.err_count}, 32'd8);

        // Asynchronous reset mid-lock
        #3;
        rst1 = 1'b1;
        #1;
        chk("async_unlock", {31'd0, b1.locked}, 32'd0);
        chk("async_count", {16'd0, b1.err_count}, 32'd0);
        @(posedge clk);
        #1;
        rst1 = 1'b0;

        // All-zero stream never locks
        locked_seen = 1'b0;
        repeat (500) tick1(1'b0, 1'b1);
        chk("zero_nolock", {31'd0, locked_seen}, 32'd0);
        chk("zero_count", {16'd0, b1.err_count}, 32'd0);

        // Gapped valid with garbage on invalid cycles
        rst1 = 1'b1;
        @(posedge clk);
        #1;
        rst1 = 1'b0;
        g = 31'h0F0F_3C3C;
        nv = 0;
        while (nv < 94) begin
            r = $urandom_range(1, 0);
            if (r[0]) begin
                gen(gb);
                tick1(gb, 1'b1);
                nv++;
            end else begin
                r = $urandom_range(1, 0);
                tick1(r[0], 1'b0);
            end
        end
        chk("gap_bit94", {31'd0, b1.locked}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            r = $urandom_range(1, 0);
            tick1(r[0], 1'b0);
        end
        chk("gap_frozen", {31'd0, b1.locked}, 32'd0);
        gen(gb);
        tick1(gb, 1'b1);
        chk("gap_bit95", {31'd0, b1.locked}, 32'd1);
        pulse_seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(1, 0);
            if (r[0]) begin
                gen(gb);
                tick1(gb, 1'b1);
            end else begin
                r = $urandom_range(1, 0);
                tick1(r[0], 1'b0);
            end
        end
        chk("gap_nopulse", {31'd0, pulse_seen}, 32'd0);
        chk("gap_count", {16'd0, b1.err_count}, 32'd0);
        chk("gap_locked", {31'd0, b1.locked}, 32'd1);

        // Saturation on the instance that cannot lose lock
        rst2 = 1'b0;
        g = 31'h1A5A_1234;
        for (int i = 0; i < 95; i++) begin
            gen(gb);
            tick2(gb, 1'b1);
        end
        chk("sat_locked", {31'd0, b2.locked}, 32'd1);
        for (int i = 0; i < 65535; i++) begin
            gen(gb);
            tick2(~gb, 1'b1);
        end
        chk("sat_ffff", {16'd0, b2.err_count}, 32'h0000_FFFF);
        for (int i = 0; i < 5; i++) begin
            gen(gb);
            tick2(~gb, 1'b1);
        end
        chk("sat_hold", {16'd0, b2.err_count}, 32'h0000_FFFF);
        chk("sat_still_locked", {31'd0, b2.locked}, 32'd1);
        b2.clr_cnt = 1'b1;
        gen(gb);
        tick2(~gb, 1'b1);
        chk("clr_with_err", {16'd0, b2.err_count}, 32'd1);
        chk("clr_with_err_pulse", {31'd0, b2.err_pulse}, 32'd1);
        tick2(1'b0, 1'b0);
        b2.clr_cnt = 1'b0;
        chk("clr_alone", {16'd0, b2.err_count}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
